// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed, checksummed byte stream into 16-bit instruction memory writes.
// Latency: wren pulses the cycle after the LO byte of each word is accepted; status is registered.
// Backpressure: none; every byte_valid cycle consumes one byte, and the idle timeout flags stalled streams.
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter logic [15:0] MAX_WORDS = 16'd4096,
  parameter logic [19:0] TIMEOUT   = 20'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [15:0] wraddress,
  output logic [15:0] wdata,
  output logic        wren,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q;
  logic [7:0]  len_hi_q;
  logic [15:0] len_q;
  logic [7:0]  data_hi_q;
  logic [7:0]  sum_q;
  logic [19:0] timer_q;
  logic [15:0] wraddress_q;
  logic [15:0] wdata_q;
  logic        wren_q;
  logic        cpu_hold_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] words_q;

  logic        loading;
  logic [15:0] len_d;
  logic [7:0]  sum_d;
  logic [19:0] timer_d;
  logic        timeout_hit;
  logic        last_word;

  // Per-byte helper values: assembled length, running checksum, idle timer and end-of-image test.
  always_comb begin
    loading     = 1'b0;
    len_d       = {len_hi_q, byte_in};
    sum_d       = sum_q + byte_in;
    timer_d     = timer_q;
    timeout_hit = 1'b0;
    // words_q already includes every earlier word: writes are at least two cycles apart.
    last_word   = ((words_q + 16'd1) == len_q);
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM: loading = 1'b1;
      default:                                          loading = 1'b0;
    endcase
    if (loading) begin
      if (byte_valid) begin
        timer_d = 20'd0;
      end else begin
        timer_d = timer_q + 20'd1;
        // The cycle in which the idle count would reach TIMEOUT; a byte in that cycle still counts.
        timeout_hit = (timer_q == (TIMEOUT - 20'd1));
      end
    end
  end

  // Loader FSM with all outputs registered; write data/address are captured with the LO byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_hi_q    <= 8'd0;
      len_q       <= 16'd0;
      data_hi_q   <= 8'd0;
      sum_q       <= 8'd0;
      timer_q     <= 20'd0;
      wraddress_q <= BASE_ADDR;
      wdata_q     <= 16'd0;
      wren_q      <= 1'b0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= 16'd0;
    end else begin
      wren_q  <= 1'b0;
      timer_q <= timer_d;
      // The word counter trails the write pulse by one cycle.
      if (wren_q) begin
        words_q <= words_q + 16'd1;
      end

      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q    <= S_LEN_HI;
            sum_q      <= 8'd0;
            words_q    <= 16'd0;
            timer_q    <= 20'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
          end
        end

        S_LEN_HI: begin
          if (byte_valid) begin
            len_hi_q <= byte_in;
            sum_q    <= sum_d;
            state_q  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (byte_valid) begin
            len_q <= len_d;
            sum_q <= sum_d;
            if (len_d == 16'd0) begin
              state_q <= S_CSUM;
            end else if (len_d > MAX_WORDS) begin
              state_q    <= S_ERR;
              error_q    <= 1'b1;
              cpu_hold_q <= 1'b1;
            end else begin
              state_q <= S_DATA_HI;
            end
          end
        end

        S_DATA_HI: begin
          if (byte_valid) begin
            data_hi_q <= byte_in;
            sum_q     <= sum_d;
            state_q   <= S_DATA_LO;
          end
        end

        S_DATA_LO: begin
          if (byte_valid) begin
            sum_q       <= sum_d;
            wdata_q     <= {data_hi_q, byte_in};
            wraddress_q <= BASE_ADDR + words_q;
            wren_q      <= 1'b1;
            state_q     <= last_word ? S_CSUM : S_DATA_HI;
          end
        end

        S_CSUM: begin
          if (byte_valid) begin
            if (byte_in == sum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q    <= S_ERR;
              error_q    <= 1'b1;
              cpu_hold_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // A stalled stream aborts the load; timeout_hit implies no byte, so no case branch acted.
      if (timeout_hit) begin
        state_q    <= S_ERR;
        error_q    <= 1'b1;
        cpu_hold_q <= 1'b1;
      end
    end
  end

  assign wraddress    = wraddress_q;
  assign wdata        = wdata_q;
  assign wren         = wren_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader; the writer side of the instruction memory that the fetch stage reads.
- Takes a byte stream (e.g. from a UART receiver), assembles big-endian 16-bit instruction words, and writes them to instruction memory through the wraddress/data/wren write port.
- Holds the CPU (cpu_hold) until the image has loaded and its checksum passes.

Parameters:
- BASE_ADDR, 16'd0, word address of the first instruction written.
- MAX_WORDS, 16'd4096, largest accepted image length in words.
- TIMEOUT, 20'd1000000, largest allowed idle cycles between bytes while loading.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_in  in  8  incoming stream byte.
- byte_valid  in  1  byte_in valid this cycle; every valid cycle consumes one byte, with no backpressure.
- wraddress  out  16  instruction memory write word address.
- wdata  out  16  instruction memory write data.
- wren  out  1  instruction memory write enable, one-cycle pulse.
- cpu_hold  out  1  high while the CPU must stay in reset/stall.
- done  out  1  image loaded and checksum OK.
- error  out  1  load failed.
- words_loaded  out  16  count of words written in the current load.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, wraddress=BASE_ADDR, wdata=0, wren=0, cpu_hold=1, done=0, error=0, words_loaded=0, checksum=0, timer=0.
- Frame format: LEN_HI, LEN_LO, then LEN words (each HI byte then LO byte), then CSUM.
  - CSUM = 8-bit sum mod 256 of every preceding frame byte, length bytes included.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR.
- IDLE:
  - start -> LEN_HI; clear checksum, words_loaded and timer; cpu_hold=1.
  - byte_valid in IDLE is ignored.
- LEN_HI -> LEN_LO on a byte.
- LEN_LO, on a byte:
  - len==0 -> CSUM.
  - len>MAX_WORDS -> ERR.
  - otherwise -> DATA_HI.
- DATA_HI: on a byte, latch the high byte -> DATA_LO.
- DATA_LO, on a byte, at the next posedge:
  - wdata={hi,byte_in}, wraddress=BASE_ADDR+words_loaded, wren=1 for exactly that one cycle.
  - words_loaded increments one cycle after the wren pulse.
  - If that was the last word -> CSUM, else -> DATA_HI.
- Write latency: wren is asserted in the cycle after the LO byte is accepted. Back-to-back valid bytes are legal; the minimum spacing of write pulses is 2 cycles.
- wraddress wraps mod 2^16; no error is raised on wrap.
- Checksum: every byte accepted in LEN_HI..DATA_LO is added mod 256 into the running sum.
- CSUM, on a byte:
  - byte == sum -> DONE: done=1, cpu_hold=0.
  - byte != sum -> ERR: error=1, cpu_hold stays 1.
- DONE and ERR are sticky; byte_valid is ignored there.
  - start clears done/error, sets cpu_hold=1, and goes to LEN_HI.
- start while in LEN_HI..CSUM is ignored; the load continues.
- Timeout:
  - timer counts cycles without byte_valid in LEN_HI..CSUM and resets to 0 on each byte.
  - timer reaching TIMEOUT -> ERR.
  - A byte arriving in the same cycle the timer reaches TIMEOUT is accepted, and no error is raised.
- Reset mid-load: returns to IDLE immediately with cpu_hold=1. Already-written memory contents are not rolled back.
- wren is never asserted outside DATA_LO completion.

Test Plan:
- Reset, then start; send 00 02 12 34 AB CD C0 -> wren pulses with (addr 0, 1234) then (addr 1, ABCD); then done=1, cpu_hold=0, words_loaded=2.
- Same frame with trailer C1 -> error=1, done=0, cpu_hold=1; a new start plus the correct frame -> done=1.
- Length 0: send 00 00 00 -> done=1, no wren pulse.
- Length 0x1001 with MAX_WORDS=4096 -> ERR right after LEN_LO, no writes.
- TIMEOUT=16: send 00 01 12, then stall 16 cycles -> error=1. Repeat with a byte arriving exactly at cycle 16 -> accepted, no error.
- Assert rst_n=0 for one cycle after the HI byte of word 3 -> IDLE, cpu_hold=1, wren=0; byte_valid pulses are ignored until start.
